// File: rtl/edge_evt_pkg.sv
// edge_evt_pkg -- shared types and defaults for the edge event arbiter, rev 1.0
`default_nettype none

package edge_evt_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_e;

  localparam int unsigned DEFAULT_NUM_CH = 4;

endpackage

`default_nettype wire

// File: rtl/ch_edge_det.sv
// ch_edge_det -- one-channel level register plus mode-selected edge detect, rev 1.0
`default_nettype none

module ch_edge_det
  import edge_evt_pkg::*;
#(
  parameter edge_mode_e EDGE_MODE = EDGE_BOTH
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic edge_o
);

  logic sig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  always_comb begin
    edge_o = 1'b0;
    case (EDGE_MODE)
      EDGE_RISE: edge_o = ~sig_q & sig_i;
      EDGE_FALL: edge_o = sig_q & ~sig_i;
      default:   edge_o = sig_q ^ sig_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter -- per-channel edge capture, round-robin event presentation, rev 1.0
`default_nettype none

module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int unsigned NUM_CH    = DEFAULT_NUM_CH,
  parameter edge_mode_e  EDGE_MODE = EDGE_BOTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         sig,
  input  logic [NUM_CH-1:0]         ch_en,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [$clog2(NUM_CH)-1:0] evt_ch,
  output logic [NUM_CH-1:0]         ovr,
  input  logic                      ovr_clr
);

  localparam int unsigned CW = $clog2(NUM_CH);

  logic [NUM_CH-1:0] det;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] avail;
  logic [NUM_CH-1:0] gnt;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] ovr_q, ovr_d;
  logic [CW-1:0]     last_q, last_d;
  logic [CW-1:0]     evt_ch_q, evt_ch_d;
  logic              evt_valid_q, evt_valid_d;
  logic [CW-1:0]     grant_idx;
  logic              found;
  logic              load;

  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
    ch_edge_det #(
      .EDGE_MODE (EDGE_MODE)
    ) u_det (
      .clk    (clk),
      .rst    (rst),
      .sig_i  (sig[i]),
      .edge_o (det[i])
    );
  end

  assign hit   = det & ch_en;
  assign avail = pend_q & ch_en;
  assign load  = ~evt_valid_q | evt_ready;

  // Round-robin: first available channel strictly after the last grant, wrapping.
  always_comb begin
    int c;
    found     = 1'b0;
    grant_idx = '0;
    c         = 0;
    for (int off = 1; off <= int'(NUM_CH); off++) begin
      c = int'(last_q) + off;
      if (c >= int'(NUM_CH)) c = c - int'(NUM_CH);
      if (!found && avail[c]) begin
        found     = 1'b1;
        grant_idx = CW'(c);
      end
    end
  end

  always_comb begin
    gnt         = '0;
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    last_d      = last_q;
    if (load) begin
      evt_valid_d = found;
      if (found) begin
        gnt[grant_idx] = 1'b1;
        evt_ch_d       = grant_idx;
        last_d         = grant_idx;
      end
    end
    // A fresh edge in the grant cycle re-arms pend instead of being lost.
    pend_d = ((pend_q & ~gnt) | hit) & ch_en;
    ovr_d  = (ovr_q & ~{NUM_CH{ovr_clr}}) | (hit & pend_q & ~gnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= '0;
      ovr_q       <= '0;
      last_q      <= CW'(NUM_CH - 1);
      evt_ch_q    <= '0;
      evt_valid_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      ovr_q       <= ovr_d;
      last_q      <= last_d;
      evt_ch_q    <= evt_ch_d;
      evt_valid_q <= evt_valid_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign ovr       = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter -- directed and randomized checks of edge_event_arbiter, rev 1.0
`default_nettype none

module tb_edge_event_arbiter;
  import edge_evt_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [N-1:0] sig;
  logic [N-1:0] ch_en;
  logic         evt_ready;
  logic         ovr_clr;

  logic         vld0, vld1;
  logic [1:0]   ch0, ch1;
  logic [N-1:0] ovr0, ovr1;

  edge_event_arbiter #(.NUM_CH(N), .EDGE_MODE(EDGE_BOTH)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .sig       (sig),
    .ch_en     (ch_en),
    .evt_valid (vld0),
    .evt_ready (evt_ready),
    .evt_ch    (ch0),
    .ovr       (ovr0),
    .ovr_clr   (ovr_clr)
  );

  edge_event_arbiter #(.NUM_CH(N), .EDGE_MODE(EDGE_RISE)) u_dut_rise (
    .clk       (clk),
    .rst       (rst),
    .sig       (sig),
    .ch_en     (ch_en),
    .evt_valid (vld1),
    .evt_ready (evt_ready),
    .evt_ch    (ch1),
    .ovr       (ovr1),
    .ovr_clr   (ovr_clr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: per-instance event bookkeeping driven by the stated rules.
  bit [N-1:0] m_sigq[2];
  bit [N-1:0] m_pend[2];
  bit [N-1:0] m_ovr[2];
  bit         m_vld[2];
  int         m_ch[2];
  int         m_last[2];
  edge_mode_e m_mode[2];

  function automatic void m_reset();
    for (int k = 0; k < 2; k++) begin
      m_sigq[k] = '0;
      m_pend[k] = '0;
      m_ovr[k]  = '0;
      m_vld[k]  = 1'b0;
      m_ch[k]   = 0;
      m_last[k] = N - 1;
    end
  endfunction

  function automatic void m_step(input int k);
    bit [N-1:0] hit;
    bit         e;
    bit         take;
    int         g;
    int         c;
    for (int i = 0; i < N; i++) begin
      if (m_mode[k] == EDGE_RISE)      e = !m_sigq[k][i] && sig[i];
      else if (m_mode[k] == EDGE_FALL) e = m_sigq[k][i] && !sig[i];
      else                             e = m_sigq[k][i] != sig[i];
      hit[i] = e && ch_en[i];
    end
    take = !m_vld[k] || evt_ready;
    g = -1;
    if (take) begin
      for (int off = 1; off <= N; off++) begin
        c = (m_last[k] + off) % N;
        if (g < 0 && m_pend[k][c] && ch_en[c]) g = c;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (hit[i] && m_pend[k][i] && i != g) m_ovr[k][i] = 1'b1;
      else if (ovr_clr)                     m_ovr[k][i] = 1'b0;
      if (!ch_en[i])    m_pend[k][i] = 1'b0;
      else if (hit[i])  m_pend[k][i] = 1'b1;
      else if (i == g)  m_pend[k][i] = 1'b0;
    end
    if (take) begin
      m_vld[k] = (g >= 0);
      if (g >= 0) begin
        m_ch[k]   = g;
        m_last[k] = g;
      end
    end
    m_sigq[k] = sig;
  endfunction

  task automatic compare_all();
    chk("vld_both", vld0, m_vld[0]);
    if (m_vld[0]) chk("ch_both", ch0, m_ch[0]);
    chk("ovr_both", ovr0, m_ovr[0]);
    chk("vld_rise", vld1, m_vld[1]);
    if (m_vld[1]) chk("ch_rise", ch1, m_ch[1]);
    chk("ovr_rise", ovr1, m_ovr[1]);
  endtask

  task automatic cycle(input logic [N-1:0] s, input logic [N-1:0] en,
                       input logic rdy, input logic clr);
    sig       = s;
    ch_en     = en;
    evt_ready = rdy;
    ovr_clr   = clr;
    m_step(0);
    m_step(1);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic rst_pulse();
    #2 rst = 1'b1;
    #1;
    chk("rst_async_vld", vld0, 0);
    chk("rst_async_ovr", ovr0, 0);
    chk("rst_async_vld_rise", vld1, 0);
    m_reset();
    #1 rst = 1'b0;
  endtask

  initial begin
    m_mode[0] = EDGE_BOTH;
    m_mode[1] = EDGE_RISE;
    rst = 1'b1;
    sig = '0;
    ch_en = '1;
    evt_ready = 1'b1;
    ovr_clr = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_vld", vld0, 0);
    chk("reset_ch", ch0, 0);
    chk("reset_ovr", ovr0, 0);
    rst = 1'b0;

    // Single rising edge on channel 2.
    cycle(4'b0100, 4'b1111, 1'b1, 1'b0);
    chk("single_early", vld0, 0);
    cycle(4'b0100, 4'b1111, 1'b1, 1'b0);
    chk("single_vld", vld0, 1);
    chk("single_ch", ch0, 2);
    cycle(4'b0100, 4'b1111, 1'b1, 1'b0);
    chk("single_drop", vld0, 0);

    // All channels at once, then a wrap from channel 3 back to 0.
    sig = '0;
    rst_pulse();
    cycle(4'b1111, 4'b1111, 1'b1, 1'b0);
    for (int j = 0; j < N; j++) begin
      cycle(4'b1111, 4'b1111, 1'b1, 1'b0);
      chk("burst_vld", vld0, 1);
      chk("burst_ch", ch0, j);
    end
    cycle(4'b0110, 4'b1111, 1'b1, 1'b0);
    cycle(4'b0110, 4'b1111, 1'b1, 1'b0);
    chk("wrap_first", ch0, 0);
    cycle(4'b0110, 4'b1111, 1'b1, 1'b0);
    chk("wrap_second", ch0, 3);

    // Stalled consumer: overrun on channel 1, set wins over clear.
    sig = '0;
    rst_pulse();
    cycle(4'b0010, 4'b1111, 1'b0, 1'b0);
    cycle(4'b0010, 4'b1111, 1'b0, 1'b0);
    cycle(4'b0000, 4'b1111, 1'b0, 1'b0);
    chk("stall_no_ovr", ovr0, 0);
    cycle(4'b0010, 4'b1111, 1'b0, 1'b0);
    chk("stall_hold_ch", ch0, 1);
    chk("stall_ovr", ovr0, 4'b0010);
    cycle(4'b0000, 4'b1111, 1'b0, 1'b1);
    chk("set_beats_clr", ovr0, 4'b0010);
    cycle(4'b0000, 4'b1111, 1'b0, 1'b1);
    chk("clr_alone", ovr0, 0);

    // Disabled channel ignores edges.
    sig = '0;
    rst_pulse();
    for (int j = 0; j < 3; j++) begin
      cycle(4'b0100, 4'b1011, 1'b1, 1'b0);
      chk("disabled_no_evt", vld0, 0);
    end
    cycle(4'b0100, 4'b1111, 1'b1, 1'b0);
    cycle(4'b0100, 4'b1111, 1'b1, 1'b0);
    chk("reenable_no_evt", vld0, 0);

    // Rising-only instance: fall ignored, rise reported.
    sig = 4'b0001;
    rst_pulse();
    cycle(4'b0001, 4'b1111, 1'b1, 1'b0);
    cycle(4'b0001, 4'b1111, 1'b1, 1'b0);
    chk("rise_vld", vld1, 1);
    chk("rise_ch", ch1, 0);
    cycle(4'b0000, 4'b1111, 1'b1, 1'b0);
    cycle(4'b0000, 4'b1111, 1'b1, 1'b0);
    chk("fall_ignored", vld1, 0);

    // Reset while an event is presented and others are pending.
    sig = '0;
    rst_pulse();
    cycle(4'b0001, 4'b1111, 1'b0, 1'b0);
    cycle(4'b0001, 4'b1111, 1'b0, 1'b0);
    cycle(4'b0111, 4'b1111, 1'b0, 1'b0);
    chk("pre_rst_vld", vld0, 1);
    rst_pulse();
    cycle(4'b0111, 4'b1111, 1'b1, 1'b0);
    chk("post_rst_idle", vld0, 0);
    cycle(4'b0111, 4'b1111, 1'b1, 1'b0);
    chk("post_rst_first", ch0, 0);

    // Randomized traffic.
    for (int j = 0; j < 400; j++) begin
      cycle(4'($urandom),
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111,
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 99) == 0) rst_pulse();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of monitored input channels (2..16).
REQ-002 SHALL have parameter EDGE_MODE (type edge_mode_e), default EDGE_BOTH, meaning the edge type captured on all channels (EDGE_RISE, EDGE_FALL, EDGE_BOTH).
REQ-003 SHALL have port clk  input  1  the single clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port sig  input  NUM_CH  monitored levels, synchronous to clk (synchronizers external).
REQ-006 SHALL have port ch_en  input  NUM_CH  per-channel capture enable.
REQ-007 SHALL have port evt_valid  output  1  event available.
REQ-008 SHALL have port evt_ready  input  1  consumer accepts event.
REQ-009 SHALL have port evt_ch  output  $clog2(NUM_CH)  channel index of the presented event.
REQ-010 SHALL have port ovr  output  NUM_CH  sticky per-channel overrun flags.
REQ-011 SHALL have port ovr_clr  input  1  single-cycle clear of all ovr bits.

Function
REQ-012 SHALL register sig into sig_q each clk; edge per channel = ~sig_q&sig (RISE), sig_q&~sig (FALL), sig_q^sig (BOTH).
REQ-013 SHALL set pend[i] on the clk edge at which edge[i]&ch_en[i] is true.
REQ-014 SHALL clear pend[i], and ignore edges on i, while ch_en[i] is low.
REQ-015 SHALL hold one output register (evt_valid, evt_ch); it loads when empty or when evt_valid&evt_ready in the same cycle (zero-bubble back-to-back).
REQ-016 SHALL choose the load source by round-robin over pend, searching from last-granted+1 upward with wrap to 0.
REQ-017 SHALL clear pend[g] on the edge granted channel g is loaded into the output register.
REQ-018 SHALL keep pend[g] set, with no overrun, when a new edge on g arrives in its grant cycle.
REQ-019 SHALL set ovr[i] when edge[i]&ch_en[i] occurs while pend[i] is set and i is not granted that cycle; the event merges into the pending one.
REQ-020 SHALL give a set condition priority over ovr_clr in the same cycle.
REQ-021 SHALL hold evt_valid and evt_ch stable while evt_valid&~evt_ready.
REQ-022 SHALL assert evt_valid one clk after the pend set (two edges after sig changes, given an empty output register).
REQ-023 SHALL sustain one accepted event per cycle when evt_ready is held high.
REQ-024 SHALL leave a loaded event presented if its channel is disabled afterwards.

Reset
REQ-025 SHALL, on rst high, asynchronously clear sig_q, pend, ovr, evt_valid, evt_ch to 0 and set the last-granted pointer to NUM_CH-1 (channel 0 first priority).
REQ-026 SHALL treat a sig bit already high at reset release as a rising edge (sig_q resets to 0).
REQ-027 SHALL discard pending and presented events when rst asserts mid-operation; no event survives reset.

Structure
REQ-028 SHALL take edge_mode_e and the default NUM_CH constant from shared package edge_evt_pkg.
REQ-029 SHALL instantiate NUM_CH copies of sub-module ch_edge_det (sig_q register plus mode-selected edge logic), one per channel.
REQ-030 SHALL keep the round-robin arbiter, pending bits, overrun logic and output register in the top module.

Verification
REQ-031 SHALL cover: NUM_CH=4, BOTH, all enabled, ready=1, sig[2] 0->1 -> single event evt_ch=2, evt_valid two edges after sig change, high one cycle.
REQ-032 SHALL cover: sig 0000->1111 in one cycle, ready=1 -> evt_ch 0,1,2,3 on four consecutive cycles; then sig[0],sig[3] toggle -> order 0 then 3 (pointer resumed after 3).
REQ-033 SHALL cover: ready=0 with event ch1 presented, sig[1] toggles twice -> evt_ch holds 1, second toggle sets ovr=0010, ovr_clr same cycle as a third toggle leaves ovr=0010.
REQ-034 SHALL cover: ch_en=1011, sig[2] toggles -> no event, pend[2] stays 0, ovr=0000.
REQ-035 SHALL cover: EDGE_RISE, sig[0] 1->0 -> no event; 0->1 -> one event evt_ch=0.
REQ-036 SHALL cover: rst pulsed while evt_valid=1 and pend=0110 -> next cycle evt_valid=0, pend=0, ovr=0, first event after release is whatever new edges occur, channel 0 first priority.
